// File: rtl/sha256_pkg.sv
// Shared SHA-256 message schedule constants, state type and rotate helper.
// Widths, block/round counts and the sigma rotate/shift amounts.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int ROUNDS    = 64;

  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT
  } state_e;

  function automatic logic [WORD_W-1:0] ror(
    input logic [WORD_W-1:0] x,
    input int                r
  );
    return (x >> r) | (x << (WORD_W - r));
  endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational SHA-256 small sigma: ror(x,R1) ^ ror(x,R2) ^ (x >> SH).
// Ports: x_i word in, y_o sigma result.
module sha256_sched_sigma
  import sha256_pkg::*;
#(
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int SH = 3
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  assign y_o = ror(x_i, R1) ^ ror(x_i, R2) ^ (x_i >> SH);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] with handshake.
// Ports: clk, rst_n, in_valid/in_ready/in_word, out_valid/out_ready/out_word, out_idx, out_last, busy.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [5:0]  idx_q, idx_d;

  logic [31:0] buf_q [BLK_WORDS];
  logic        buf_we;
  logic [3:0]  buf_wa;
  logic [31:0] buf_wd;

  logic        in_xfer;
  logic        out_xfer;
  logic [5:0]  nxt_idx;
  logic [3:0]  n4;
  logic [31:0] s0, s1;
  logic [31:0] w_new;

  // rst_n gates in_ready so it is low for the whole reset pulse.
  assign in_ready  = rst_n & (state_q != ST_EMIT);
  assign out_valid = (state_q == ST_EMIT);
  assign out_last  = out_valid & (idx_q == LAST_IDX);
  assign busy      = (state_q != ST_IDLE);
  assign out_word  = word_q;
  assign out_idx   = idx_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Index of the word to compute next; buffer slots are t mod 16.
  assign nxt_idx = idx_q + 6'd1;
  assign n4      = nxt_idx[3:0];

  sha256_sched_sigma #(
    .R1(S0_R1),
    .R2(S0_R2),
    .SH(S0_SH)
  ) u_sig0 (
    .x_i(buf_q[n4 + 4'd1]),
    .y_o(s0)
  );

  sha256_sched_sigma #(
    .R1(S1_R1),
    .R2(S1_R2),
    .SH(S1_SH)
  ) u_sig1 (
    .x_i(buf_q[n4 - 4'd2]),
    .y_o(s1)
  );

  // (t-15) mod 16 == t+1 mod 16; buf_q[n4] still holds W[t-16].
  assign w_new = s1 + buf_q[n4 - 4'd7] + s0 + buf_q[n4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    idx_d   = idx_q;
    buf_we  = 1'b0;
    buf_wa  = cnt_q;
    buf_wd  = in_word;
    unique case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          buf_we  = 1'b1;
          buf_wa  = 4'd0;
          cnt_d   = 4'd1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_xfer) begin
          buf_we = 1'b1;
          buf_wa = cnt_q;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_EMIT;
            word_d  = buf_q[0];
            idx_d   = 6'd0;
          end
        end
      end
      ST_EMIT: begin
        if (out_xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            word_d  = 32'd0;
            idx_d   = 6'd0;
            cnt_d   = 4'd0;
          end else if (nxt_idx < 6'd16) begin
            idx_d  = nxt_idx;
            word_d = buf_q[n4];
          end else begin
            idx_d  = nxt_idx;
            word_d = w_new;
            buf_we = 1'b1;
            buf_wa = n4;
            buf_wd = w_new;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      word_q  <= 32'd0;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  // Buffer is deliberately unreset; contents are reloaded per block.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_wa] <= buf_wd;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched.
// Scoreboard of W[t] from a plain 64-entry reference schedule.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  sha256_msg_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] q [$];
  logic [31:0] blk [16];
  logic [31:0] cap [64];
  int          t_exp = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          after_last = 0;
  bit          prev_stall = 0;
  logic [31:0] held_w = 0;
  logic [5:0]  held_i = 0;
  bit          rnd = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block();
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) q.push_back(w[t]);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!done && n < 1000) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("in_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_block(input int gap_at);
    push_block();
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("gap_ready", 32'(in_ready), 32'd1);
          @(posedge clk);
          #1;
        end
      end
      send_word(blk[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      t_exp      = 0;
      prev_stall = 0;
      after_last = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_word", out_word, held_w);
        chk("hold_idx", 32'(out_idx), 32'(held_i));
      end
      if (after_last) begin
        chk("ready_after_last", 32'(in_ready), 32'd1);
        chk("valid_after_last", 32'(out_valid), 32'd0);
        chk("last_after_last", 32'(out_last), 32'd0);
        after_last = 0;
      end
      if (out_valid) begin
        chk("ready_in_emit", 32'(in_ready), 32'd0);
        chk("busy_in_emit", 32'(busy), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else chk("w", out_word, q.pop_front());
        chk("idx", 32'(out_idx), 32'(t_exp));
        chk("last", 32'(out_last), 32'(t_exp == 63));
        cap[t_exp] = out_word;
        if (t_exp == 0) first_cyc = cyc;
        if (t_exp == 63) begin
          last_cyc   = cyc;
          after_last = 1;
          t_exp      = 0;
        end else begin
          t_exp++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held_w     = out_word;
      held_i     = out_idx;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = 32'd0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    set_abc();
    load_block(-1);
    drain();
    chk("abc_w16", cap[16], 32'h61626380);
    chk("abc_w17", cap[17], 32'h000F0000);
    chk("abc_w63", cap[63], 32'h12B1EDEB);
    chk("abc_64cyc", 32'(last_cyc - first_cyc), 32'd63);

    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[14] = 32'h00000001;
    load_block(-1);
    drain();
    chk("sig1_w16", cap[16], 32'h0000A000);

    rnd = 1;
    set_abc();
    load_block(-1);
    drain();
    chk("bp_w63", cap[63], 32'h12B1EDEB);
    rnd = 0;

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(8);
    drain();

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(-1);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(-1);
    drain();

    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block(-1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 6'd30) && n < 500);
    if (n >= 500) chk("wait_t30", 32'd0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_idx", 32'(out_idx), 32'd0);
    q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    load_block(-1);
    drain();
    for (int t = 0; t < 64; t += 9) chk("zero_blk", cap[t], 32'd0);
    chk("zero_blk63", cap[63], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
